pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 150 +++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: steps a linear duty level toward a target at a programmable
// rate. Each update writes the new level to a pwm_driver through a one-cycle
// strobe.
// Optional feature: define PWM_FADE_GAMMA_EN to send a gamma-shaped value
// ((level*level + level) >> DATA_WIDTH) to the driver instead of the linear
// level. The fade itself and all of its timing are unchanged.
module pwm_fade_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DIV_WIDTH-1:0]  period_div,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] current,
  output logic                  set_cutoff_en,
  output logic [DATA_WIDTH-1:0] cutoff_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [DIV_WIDTH-1:0]  timer, timer_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] current_d, cutoff_d;
  logic [DATA_WIDTH-1:0] next_level, up_gap, down_gap;
  logic                  strobe_d, done_d, busy_d;

  // Maps a linear level onto the value the pwm_driver is given
  function automatic logic [DATA_WIDTH-1:0] shape(input logic [DATA_WIDTH-1:0] lvl);
`ifdef PWM_FADE_GAMMA_EN
    logic [2*DATA_WIDTH-1:0] lvl_w;
    logic [2*DATA_WIDTH-1:0] sq;
    lvl_w = {{DATA_WIDTH{1'b0}}, lvl};
    // Largest result is 2^(2W) - 2^W, so 2W bits cannot overflow
    sq    = lvl_w * lvl_w + lvl_w;
    return DATA_WIDTH'(sq >> DATA_WIDTH);
`else
    return lvl;
`endif
  endfunction

  // Next level one step toward the target, clamped to the target so the
  // level can neither overshoot nor wrap
  always_comb begin
    up_gap     = target_q - current;
    down_gap   = current - target_q;
    next_level = current;
    if (target_q > current) begin
      next_level = (up_gap <= step_q) ? target_q : current + step_q;
    end else if (target_q < current) begin
      next_level = (down_gap <= step_q) ? target_q : current - step_q;
    end
  end

  // Next-state and next-output decode; abort wins over every other request
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    div_d     = div_q;
    target_d  = target_q;
    step_d    = step_q;
    current_d = current;
    cutoff_d  = cutoff_value;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          target_d = target;
          step_d   = (step == '0) ? DATA_WIDTH'(1) : step;
          div_d    = period_div;
          timer_d  = period_div;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (timer == '0) begin
          state_d = STEP;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      STEP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (current != target_q) begin
          current_d = next_level;
          cutoff_d  = shape(next_level);
          strobe_d  = 1'b1;
          timer_d   = div_q;
          state_d   = WAIT;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything, including any
  // strobe or done that the same edge would otherwise have produced
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      div_q         <= '0;
      target_q      <= '0;
      step_q        <= '0;
      current       <= '0;
      cutoff_value  <= '0;
      set_cutoff_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      div_q         <= div_d;
      target_q      <= target_d;
      step_q        <= step_d;
      current       <= current_d;
      cutoff_value  <= cutoff_d;
      set_cutoff_en <= strobe_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Testbench for pwm_fade_ctrl: table of directed vectors with hand-computed
// expectations plus hand-written sequences for the long ramp and mid-fade
// reset. Honours PWM_FADE_GAMMA_EN when computing expected cutoff values.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  target = 8'd0;
  logic [7:0]  step = 8'd0;
  logic [15:0] period_div = 16'd0;
  logic        busy;
  logic        done;
  logic [7:0]  current;
  logic        set_cutoff_en;
  logic [7:0]  cutoff_value;

  int tests = 0;
  int fails = 0;
  int strobe_count = 0;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  tgt;
    logic [7:0]  stp;
    logic [15:0] div;
    int          cycles;
    logic        e_busy;
    logic        e_done;
    logic        e_strobe;
    logic [7:0]  e_cur;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pwm_fade_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .target       (target),
    .step         (step),
    .period_div   (period_div),
    .busy         (busy),
    .done         (done),
    .current      (current),
    .set_cutoff_en(set_cutoff_en),
    .cutoff_value (cutoff_value)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Count write strobes, sampled mid-cycle
  always @(negedge clk) begin
    if (set_cutoff_en === 1'b1) strobe_count++;
  end

  // Expected driver value for a given linear level
  function automatic logic [7:0] ref_shape(input logic [7:0] lvl);
`ifdef PWM_FADE_GAMMA_EN
    int p;
    p = int'(lvl) * int'(lvl) + int'(lvl);
    return 8'(p / 256);
`else
    return lvl;
`endif
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic st, input logic ab,
                              input logic [7:0] tg, input logic [7:0] sp,
                              input logic [15:0] dv, input int cyc,
                              input logic eb, input logic ed, input logic es,
                              input logic [7:0] ec, input string nm);
    vec_t v;
    v.rst_n = rst_n; v.start = st; v.abort = ab;
    v.tgt = tg; v.stp = sp; v.div = dv; v.cycles = cyc;
    v.e_busy = eb; v.e_done = ed; v.e_strobe = es; v.e_cur = ec;
    v.name = nm;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a vector for one edge, then idle inputs for the remaining cycles
  task automatic applyStimulus(input vec_t v);
    reset      = v.rst_n;
    start      = v.start;
    abort      = v.abort;
    target     = v.tgt;
    step       = v.stp;
    period_div = v.div;
    tick();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (v.cycles - 1) tick();
  endtask

  task automatic checkOutput(input vec_t v);
    logic [7:0] e_cut;
    e_cut = ref_shape(v.e_cur);
    tests++;
    if (busy !== v.e_busy || done !== v.e_done || set_cutoff_en !== v.e_strobe ||
        current !== v.e_cur || cutoff_value !== e_cut) begin
      fails++;
      $display("[TB] FAIL %s: got busy=%b done=%b strobe=%b current=%0d cutoff=%0d, expected busy=%b done=%b strobe=%b current=%0d cutoff=%0d",
               v.name, busy, done, set_cutoff_en, current, cutoff_value,
               v.e_busy, v.e_done, v.e_strobe, v.e_cur, e_cut);
    end
  endtask

  task automatic checkValue(input string nm, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, actual, expected);
    end
  endtask

  task automatic runRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
  endtask

  initial begin
    int saved;
    int gamma_128;

    // 0: reset overrides a start request
    vecs.push_back(mk(0, 1, 0,   0, 0, 0, 2, 0, 0, 0,   0, "reset state"));
    // 1-9: 0 -> 16, step 4, period_div 3: writes every 5 cycles
    vecs.push_back(mk(1, 1, 0,  16, 4, 3, 1, 1, 0, 0,   0, "A accept"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 4, 1, 0, 0,   0, "A first hold"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 1, 0, 1,   4, "A write 4"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 1, 0, 0,   4, "A strobe width"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 4, 1, 0, 1,   8, "A write 8"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 5, 1, 0, 1,  12, "A write 12"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 5, 1, 0, 1,  16, "A write 16"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 5, 1, 1, 0,  16, "A done"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 0, 0, 0,  16, "A idle"));
    // 10-16: 16 -> 0, step 5, period_div 0: clamps at 0
    vecs.push_back(mk(1, 1, 0,   0, 5, 0, 1, 1, 0, 0,  16, "B accept"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 0, 1,  11, "B write 11"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 0, 1,   6, "B write 6"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 0, 1,   1, "B write 1"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 0, 1,   0, "B write 0"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 1, 0,   0, "B done"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 0, 0, 0,   0, "B idle"));
    // 17: clear level back to 0
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 0, 0, 0,   0, "reset clears level"));
    // 18-25: 0 -> 200 step 50, abort in STEP before the third write
    vecs.push_back(mk(1, 1, 0, 200, 50, 1, 4, 1, 0, 1,  50, "D write 50"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 3, 1, 0, 1, 100, "D write 100"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 0, 0, 100, "D before abort"));
    vecs.push_back(mk(1, 0, 1,   0, 0, 0, 1, 0, 0, 0, 100, "D abort"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 3, 0, 0, 0, 100, "D stays idle"));
    vecs.push_back(mk(1, 1, 0, 110, 10, 0, 3, 1, 0, 1, 110, "D restart write"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 1, 1, 0, 110, "D restart done"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 110, "D restart idle"));
    // 26-32: starts while busy are ignored; start with abort in IDLE
    vecs.push_back(mk(1, 1, 0, 120, 5, 0, 1, 1, 0, 0, 110, "E accept"));
    vecs.push_back(mk(1, 1, 0, 200, 1, 0, 2, 1, 0, 1, 115, "E start in WAIT"));
    vecs.push_back(mk(1, 1, 0,   7, 1, 0, 2, 1, 0, 1, 120, "E start again"));
    vecs.push_back(mk(1, 1, 0,   9, 1, 0, 2, 1, 1, 0, 120, "E done"));
    vecs.push_back(mk(1, 1, 0,  50, 1, 0, 1, 0, 0, 0, 120, "E start in DONE"));
    vecs.push_back(mk(1, 1, 1,  60, 1, 0, 1, 0, 0, 0, 120, "E start+abort"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 2, 0, 0, 0, 120, "E still idle"));
    // 33-35: target already reached: no write, still done
    vecs.push_back(mk(1, 1, 0, 120, 3, 2, 4, 1, 0, 0, 120, "F equal in STEP"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 1, 1, 0, 120, "F equal done"));
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 120, "F equal idle"));

    runRange(0, 16);

    // Long ramp 0 -> 255 with step 0 (acts as 1), one write every 2 cycles
`ifdef PWM_FADE_GAMMA_EN
    gamma_128 = 64;
`else
    gamma_128 = 128;
`endif
    applyStimulus(mk(1, 1, 0, 255, 0, 0, 1, 1, 0, 0, 0, "C accept"));
    checkOutput(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "C accept"));
    for (int i = 1; i <= 255; i++) begin
      repeat (2) tick();
      checkOutput(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 8'(i), "C ramp"));
      if (i == 128) checkValue("C cutoff at 128", int'(cutoff_value), gamma_128);
    end
    repeat (2) tick();
    checkOutput(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 8'd255, "C done"));
    tick();
    checkOutput(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'd255, "C idle"));

    runRange(17, 32);
    saved = strobe_count;
    runRange(33, 35);
    checkValue("F equal no write", strobe_count, saved);

    // Reset mid-fade, with start and abort also high
    applyStimulus(mk(1, 1, 0, 200, 10, 1, 4, 1, 0, 1, 130, "G write 130"));
    checkOutput(mk(1, 1, 0, 200, 10, 1, 4, 1, 0, 1, 130, "G write 130"));
    applyStimulus(mk(0, 1, 1, 200, 10, 1, 1, 0, 0, 0, 0, "G reset"));
    checkOutput(mk(0, 1, 1, 200, 10, 1, 1, 0, 0, 0, 0, "G reset"));
    saved = strobe_count;
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, "G after reset"));
    checkOutput(mk(1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, "G after reset"));
    checkValue("G no strobe after reset", strobe_count, saved);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
